pwm_receiver: RTL and testbench
===============================

// Module: pwm_receiver
// PURPOSE
//  Measures the high time of an incoming 1-2 ms / 20 ms servo-style PWM pulse (RC receiver channel).
//  Converts it to an 8-bit width on the same scale the PWM generator uses (0 = 1 ms, 255 = 2 ms).
//  Sits between an external RC receiver pin and the peripheral register file.
//  Supplies a command value, a valid flag and a per-sample strobe; signal loss drives the output to neutral.
// PARAMETERS
//  DIV_FACTOR     47    clk_12MHz cycles per measurement tick (~255.3 kHz, ~3.92 us/tick)
//  MIN_TICKS      204   shortest accepted high time (~0.8 ms); shorter = glitch
//  MAX_TICKS      561   longest accepted high time (~2.2 ms); longer = glitch
//  TIMEOUT_TICKS  6375  ticks without an accepted pulse before loss of signal (~25 ms)
// PORTS
//  clk_12MHz    in   1  system clock
//  reset        in   1  synchronous, active-low reset (0 = reset)
//  pwm_in       in   1  raw PWM pin, asynchronous to clk_12MHz
//  width        out  8  last accepted pulse width; 0 = 1 ms, 255 = 2 ms, 127 = neutral
//  valid        out  1  1 = pulses accepted within the last TIMEOUT_TICKS
//  sample_stb   out  1  one-cycle pulse whenever width is updated from a measured pulse
//  glitch_count out  8  saturating count of rejected pulses
// BEHAVIOUR
//  Reset (reset==0 at posedge): width=127, valid=0, sample_stb=0, glitch_count=0,
//    state=WAIT_LOW, prescaler=0, high_cnt=0, timeout_cnt=0.
//  Input conditioning: 2-FF synchronizer, then a registered copy for edge detection.
//    Edge = sync2 != prev.
//  Tick: free-running prescaler counts 0..DIV_FACTOR-1; tick=1 for one cycle at wrap.
//    Counters advance only on tick.
//  FSM:
//    WAIT_LOW  : ignore input until sync2==0. Prevents measuring a partial pulse after reset.
//                Next state WAIT_RISE.
//    WAIT_RISE : on rising edge, clear high_cnt. Next state HIGH.
//    HIGH      : high_cnt++ on tick.
//                Falling edge -> evaluate, then go to WAIT_RISE.
//                high_cnt > MAX_TICKS while still high -> reject, glitch_count++, go to WAIT_LOW.
//                  Stuck-high lines never wrap the counter.
//  Evaluate (cycle of falling-edge detect): h = high_cnt (13 bit).
//    h < MIN_TICKS or h > MAX_TICKS -> reject. glitch_count++ (saturates at 255).
//      width, valid and timeout are untouched.
//    Otherwise accept:
//      width = (h<255) ? 0 : (h>510) ? 255 : h-255.
//      valid=1, timeout_cnt=0, sample_stb=1 for exactly one cycle.
//  Latency: width and sample_stb change on the 3rd posedge after pwm_in's falling edge is sampled.
//    2 sync stages + 1 registered evaluate.
//  Resolution: +/-1 tick, from the unsynchronized tick phase.
//  Timeout: timeout_cnt++ on tick, saturating at TIMEOUT_TICKS.
//    Reaching TIMEOUT_TICKS -> valid=0, width=127 in the same cycle; no sample_stb.
//    The next accepted pulse restores valid=1.
//  Simultaneous accept and timeout in one cycle: accept wins (valid=1, width=measured).
//  Reset mid-pulse: the held-high input is ignored. The first measurement follows a full low period.
//  All outputs registered; no combinational path from pwm_in.
// STRUCTURE
//  pwm_pkg (shared with the generator):
//    PWM_OFFSET_TICKS=255, PWM_NEUTRAL=8'd127, PWM_PERIOD_TICKS=5100.
//    typedef enum {WAIT_LOW, WAIT_RISE, HIGH} pwm_rx_state_t.
//  Sub-module pwm_edge_sync: 2-FF synchronizer + prev register.
//    Outputs level, rise, fall; reset to 0.
//  Prescaler, FSM, counters and conversion live in pwm_receiver itself.
// TESTING
//  1. Reset, pin low, 20 ms frames of 1.500 ms high
//     -> sample_stb every 20 ms, width=127 or 128, valid=1.
//  2. 1.000 ms and 2.000 ms pulses -> width 0 (+1 max) and 255 (-1 max).
//     2.100 ms -> 255 (clamp). 0.900 ms -> 0 (clamp).
//  3. 0.500 ms pulse, then 2.500 ms pulse after a valid 1.5 ms frame
//     -> no sample_stb, width holds 127/128, glitch_count=2.
//  4. Valid stream, then pin held low 30 ms -> valid falls 25 ms (+/-1 tick) after the last
//     accepted fall, width=127. The next 1.2 ms pulse restores valid=1, width ~51.
//  5. Assert reset while pin high mid-pulse, release, pin stays high 1 ms then 20 ms frames
//     -> no sample for the partial pulse; the first sample comes from the next full pulse.
//  6. Pin stuck high 50 ms -> glitch_count=1 at ~2.2 ms, valid=0 at timeout, counters never wrap.
//     Then 300 glitch pulses -> glitch_count saturates at 255.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM scale definitions used by both the servo PWM generator and receiver.
// Widths are in measurement ticks: 255 ticks of offset maps 1 ms to code 0.
package pwm_pkg;

    localparam int         PWM_OFFSET_TICKS = 255;
    localparam logic [7:0] PWM_NEUTRAL      = 8'd127;
    localparam int         PWM_PERIOD_TICKS = 5100;
    localparam int         CNT_W            = 13;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } pwm_rx_state_t;

    // Map a measured high time to the 8-bit command scale, clamping both ends.
    function automatic logic [7:0] ticks_to_width(input logic [CNT_W-1:0] h);
        logic [CNT_W-1:0] d;
        d = h - CNT_W'(PWM_OFFSET_TICKS);
        if (h < CNT_W'(PWM_OFFSET_TICKS)) begin
            return 8'd0;
        end else if (h > CNT_W'(2 * PWM_OFFSET_TICKS)) begin
            return 8'd255;
        end else begin
            return d[7:0];
        end
    endfunction

endpackage

// File: rtl/pwm_receiver_if.sv
// Pin-to-register-file signal bundle of the PWM receiver.
// master is the receiver side, slave is the consumer that owns the pin stimulus.
interface pwm_receiver_if;

    logic       pwm_in;
    logic [7:0] width;
    logic       valid;
    logic       sample_stb;
    logic [7:0] glitch_count;

    modport master (
        input  pwm_in,
        output width,
        output valid,
        output sample_stb,
        output glitch_count
    );

    modport slave (
        output pwm_in,
        input  width,
        input  valid,
        input  sample_stb,
        input  glitch_count
    );

endinterface

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM pin plus a delayed copy for edge detection.
// ready_o rises once both synchronizer stages hold samples taken after reset.
module pwm_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic ready_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] settle_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            settle_q <= 2'b00;
        end else begin
            sync1_q  <= async_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;
    assign fall_o  = ~sync2_q & prev_q;
    assign ready_o = settle_q[1];

endmodule

// File: rtl/pwm_receiver.sv
// RC servo pulse receiver: measures pin high time in prescaled ticks and converts it
// to the 8-bit command scale, with glitch rejection and loss-of-signal fallback to neutral.
module pwm_receiver
    import pwm_pkg::*;
#(
    parameter int DIV_FACTOR    = 47,
    parameter int MIN_TICKS     = 204,
    parameter int MAX_TICKS     = 561,
    parameter int TIMEOUT_TICKS = 6375
) (
    input  logic           clk_12MHz,
    input  logic           reset,
    pwm_receiver_if.master bus
);

    localparam int PRE_W = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;

    logic level, rise, fall, sync_ready;

    pwm_edge_sync u_edge_sync (
        .clk_i   (clk_12MHz),
        .rst_ni  (reset),
        .async_i (bus.pwm_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall),
        .ready_o (sync_ready)
    );

    pwm_rx_state_t    state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [7:0]       width_q, width_d;
    logic             valid_q, valid_d;
    logic             stb_q, stb_d;
    logic [7:0]       glitch_q, glitch_d;
    logic             tick, accept, reject;

    assign tick    = (presc_q == PRE_W'(DIV_FACTOR - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        timeout_d  = timeout_q;
        width_d    = width_q;
        valid_d    = valid_q;
        stb_d      = 1'b0;
        glitch_d   = glitch_q;
        accept     = 1'b0;
        reject     = 1'b0;

        // Loss of signal drops to neutral on the tick that reaches the limit.
        if (tick && timeout_q != CNT_W'(TIMEOUT_TICKS)) begin
            timeout_d = timeout_q + 1'b1;
            if (timeout_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                valid_d = 1'b0;
                width_d = PWM_NEUTRAL;
            end
        end

        unique case (state_q)
            WAIT_LOW: begin
                if (sync_ready && !level) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    high_cnt_d = '0;
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                if (tick) high_cnt_d = high_cnt_q + 1'b1;
                if (fall) begin
                    state_d = WAIT_RISE;
                    if (high_cnt_q < CNT_W'(MIN_TICKS) || high_cnt_q > CNT_W'(MAX_TICKS)) begin
                        reject = 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                end else if (high_cnt_q > CNT_W'(MAX_TICKS)) begin
                    // Stuck-high line: give up before the counter can wrap.
                    reject  = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            default: state_d = WAIT_LOW;
        endcase

        // Accept overrides a coincident timeout.
        if (accept) begin
            width_d   = ticks_to_width(high_cnt_q);
            valid_d   = 1'b1;
            timeout_d = '0;
            stb_d     = 1'b1;
        end
        if (reject && glitch_q != 8'hFF) glitch_d = glitch_q + 1'b1;
    end

    always_ff @(posedge clk_12MHz) begin
        if (!reset) begin
            state_q    <= WAIT_LOW;
            presc_q    <= '0;
            high_cnt_q <= '0;
            timeout_q  <= '0;
            width_q    <= PWM_NEUTRAL;
            valid_q    <= 1'b0;
            stb_q      <= 1'b0;
            glitch_q   <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            high_cnt_q <= high_cnt_d;
            timeout_q  <= timeout_d;
            width_q    <= width_d;
            valid_q    <= valid_d;
            stb_q      <= stb_d;
            glitch_q   <= glitch_d;
        end
    end

    assign bus.width        = width_q;
    assign bus.valid        = valid_q;
    assign bus.sample_stb   = stb_q;
    assign bus.glitch_count = glitch_q;

endmodule

// File: tb/tb_pwm_receiver.sv
// Scoreboard bench for pwm_receiver; prescaler shortened to 2 clocks per tick so
// full-length pulses fit in a short run while tick-domain thresholds stay as specified.
module tb_pwm_receiver;

    localparam int DIV = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   last_stb_cyc;
    int   exp_q[$];
    int   exp_glitch;

    typedef struct {
        int hc;
        int w;
    } vec_t;

    pwm_receiver_if bus_if ();

    pwm_receiver #(
        .DIV_FACTOR    (DIV),
        .MIN_TICKS     (204),
        .MAX_TICKS     (561),
        .TIMEOUT_TICKS (6375)
    ) dut (
        .clk_12MHz (clk),
        .reset     (rst_n),
        .bus       (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation within one tick.
    always @(negedge clk) begin
        if (rst_n && bus_if.sample_stb) begin
            last_stb_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample got width %0d expected no strobe", bus_if.width);
            end else begin
                int e;
                int d;
                e = exp_q.pop_front();
                d = int'(bus_if.width) - e;
                if (d < -1 || d > 1) begin
                    errors++;
                    $display("FAIL sample_width got %0d expected %0d+/-1", bus_if.width, e);
                end
            end
            chk("sample_valid", int'(bus_if.valid), 1);
        end
    end

    task automatic pulse(input int high_cyc, input int low_cyc, input bit accept, input int exp_w);
        if (accept) exp_q.push_back(exp_w);
        @(negedge clk);
        bus_if.pwm_in = 1'b1;
        repeat (high_cyc) @(negedge clk);
        bus_if.pwm_in = 1'b0;
        repeat (low_cyc) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        exp_glitch = 0;
    endtask

    initial begin
        vec_t t2[7];
        int   dt;
        t2 = '{'{510, 0}, '{1020, 255}, '{1072, 255}, '{460, 0},
               '{420, 0}, '{892, 191}, '{612, 51}};
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        last_stb_cyc  = 0;
        exp_glitch    = 0;
        rst_n         = 1'b0;
        bus_if.pwm_in = 1'b0;

        // Reset state
        do_reset();
        chk("rst_width", int'(bus_if.width), 127);
        chk("rst_valid", int'(bus_if.valid), 0);
        chk("rst_stb", int'(bus_if.sample_stb), 0);
        chk("rst_glitch", int'(bus_if.glitch_count), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1.5 ms frames
        for (int i = 0; i < 3; i++) pulse(766, 400, 1'b1, 128);
        drain("t1_drain");
        chk("t1_valid", int'(bus_if.valid), 1);

        // Scale endpoints, clamps and just above the minimum
        foreach (t2[i]) pulse(t2[i].hc, 400, 1'b1, t2[i].w);
        drain("t2_drain");

        // Short and long glitches after a good frame, then just below the minimum
        pulse(766, 400, 1'b1, 128);
        drain("t3_pre_drain");
        pulse(254, 400, 1'b0, 0);
        pulse(1276, 400, 1'b0, 0);
        exp_glitch += 2;
        chk("t3_glitch2", int'(bus_if.glitch_count), exp_glitch);
        chk_rng("t3_width_hold", int'(bus_if.width), 127, 128);
        chk("t3_valid_hold", int'(bus_if.valid), 1);
        pulse(400, 400, 1'b0, 0);
        exp_glitch += 1;
        chk("t3_glitch_min", int'(bus_if.glitch_count), exp_glitch);

        // Loss of signal then recovery
        pulse(766, 400, 1'b1, 128);
        drain("t4_drain");
        for (int i = 0; i < 20000 && bus_if.valid; i++) @(negedge clk);
        dt = cyc - last_stb_cyc;
        chk_rng("t4_timeout_cycles", dt, 6375 * DIV - 2, 6375 * DIV + 2);
        chk("t4_valid_lost", int'(bus_if.valid), 0);
        chk("t4_width_neutral", int'(bus_if.width), 127);
        pulse(612, 400, 1'b1, 51);
        drain("t4_recover_drain");
        chk("t4_valid_back", int'(bus_if.valid), 1);

        // Reset while the pin is held high mid-pulse
        bus_if.pwm_in = 1'b1;
        repeat (200) @(negedge clk);
        do_reset();
        rst_n = 1'b1;
        repeat (510) @(negedge clk);
        bus_if.pwm_in = 1'b0;
        repeat (400) @(negedge clk);
        chk("t5_no_partial_valid", int'(bus_if.valid), 0);
        pulse(766, 400, 1'b1, 128);
        drain("t5_drain");
        chk("t5_glitch_cleared", int'(bus_if.glitch_count), 0);

        // Stuck high, then saturate the glitch counter
        @(negedge clk);
        bus_if.pwm_in = 1'b1;
        repeat (1000) @(negedge clk);
        chk("t6_glitch_before_max", int'(bus_if.glitch_count), exp_glitch);
        repeat (300) @(negedge clk);
        exp_glitch += 1;
        chk("t6_glitch_at_max", int'(bus_if.glitch_count), exp_glitch);
        repeat (24200) @(negedge clk);
        chk("t6_glitch_no_wrap", int'(bus_if.glitch_count), exp_glitch);
        chk("t6_valid_timeout", int'(bus_if.valid), 0);
        chk("t6_width_neutral", int'(bus_if.width), 127);
        bus_if.pwm_in = 1'b0;
        repeat (400) @(negedge clk);
        for (int i = 0; i < 300; i++) pulse(20, 20, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("t6_glitch_sat", int'(bus_if.glitch_count), 255);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
